// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Purpose:
//   Turns decoded RV32I instruction requests (opcode class, register indices,
//   funct fields and a signed byte immediate) into 32-bit instruction words.
//   Each word is tagged with the byte address it will occupy in instruction
//   memory. Tagged words are buffered in a small FIFO for the memory writer.
//
// Parameters:
//   BASE_ADDR  byte address given to the first word enqueued after reset
//   DEPTH      output FIFO entries (power of two, >= 2)
//
// Ports:
//   clk         single clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   req_valid   request present
//   req_ready   request accepted this cycle when req_valid is also high
//   req_opcode  instruction class opcode
//   req_funct3  funct3 field
//   req_funct7  instruction bit 30 (SUB / arithmetic-shift variant)
//   req_rd      destination register index
//   req_rs1     first source register index
//   req_rs2     second source register index
//   req_imm     signed byte immediate (U-type uses the upper 20 bits)
//   out_valid   head FIFO entry valid
//   out_ready   consumer takes the head entry
//   out_instr   encoded instruction word of the head entry
//   out_addr    byte address of the head entry
//   err         one-cycle pulse after a rejected opcode or truncated immediate
//   fifo_count  number of entries held
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [6:0]                 req_opcode,
  input  logic [2:0]                 req_funct3,
  input  logic                       req_funct7,
  input  logic [4:0]                 req_rd,
  input  logic [4:0]                 req_rs1,
  input  logic [4:0]                 req_rs2,
  input  logic [31:0]                req_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_addr,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ALU   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   addr_mem  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   next_addr;

  logic [31:0]   enc_word;
  logic          enc_supported;
  logic          enc_trunc;
  logic          fits12;
  logic          fits13;
  logic          fits21;
  logic          accept;
  logic          enq;
  logic          pop;

  // Handshake decode. req_ready depends only on registered occupancy and
  // rst, so the consumer's out_ready never ripples through to the producer;
  // a full FIFO therefore refuses a request even if a pop happens that cycle.
  always_comb begin
    req_ready = !rst && (count != CW'(DEPTH));
    out_valid = (count != '0);
    accept    = req_valid && req_ready;
    pop       = out_valid && out_ready;
    enq       = accept && enc_supported;
  end

  // Signed-range tests: an immediate fits an N-bit signed field when every
  // bit above the field's sign bit is a copy of that sign bit.
  always_comb begin
    fits12 = (req_imm[31:11] == {21{req_imm[11]}});
    fits13 = (req_imm[31:12] == {20{req_imm[12]}});
    fits21 = (req_imm[31:20] == {12{req_imm[20]}});
  end

  // Instruction encoder. Every supported class always produces a word from
  // the low immediate bits; enc_trunc only flags that bits were lost (or a
  // branch/jump offset was odd). Shift-immediate ALU ops carry a 5-bit
  // unsigned shamt, so they flag anything outside 0..31.
  always_comb begin
    enc_word      = '0;
    enc_supported = 1'b1;
    enc_trunc     = 1'b0;
    case (req_opcode)
      OP_R: begin
        enc_word = {1'b0, req_funct7, 5'b0, req_rs2, req_rs1, req_funct3,
                    req_rd, req_opcode};
      end
      OP_LOAD, OP_JALR: begin
        enc_word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
        enc_trunc = !fits12;
      end
      OP_ALU: begin
        if (req_funct3 == 3'b001 || req_funct3 == 3'b101) begin
          enc_word  = {1'b0, req_funct7, 5'b0, req_imm[4:0], req_rs1,
                       req_funct3, req_rd, req_opcode};
          enc_trunc = (req_imm[31:5] != '0);
        end else begin
          enc_word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
          enc_trunc = !fits12;
        end
      end
      OP_STORE: begin
        enc_word  = {req_imm[11:5], req_rs2, req_rs1, req_funct3,
                     req_imm[4:0], req_opcode};
        enc_trunc = !fits12;
      end
      OP_BR: begin
        enc_word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                     req_imm[4:1], req_imm[11], req_opcode};
        enc_trunc = !fits13 || req_imm[0];
      end
      OP_AUIPC, OP_LUI: begin
        enc_word = {req_imm[31:12], req_rd, req_opcode};
      end
      OP_JAL: begin
        enc_word  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                     req_rd, req_opcode};
        enc_trunc = !fits21 || req_imm[0];
      end
      default: begin
        enc_supported = 1'b0;
      end
    endcase
  end

  // FIFO storage. Contents need no reset: nothing is visible unless the
  // occupancy count says the slot holds a live entry.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr] <= enc_word;
      addr_mem[wr_ptr]  <= next_addr;
    end
  end

  // Pointers, occupancy, address counter and the error pulse. Pointers are
  // PW bits wide so they wrap modulo DEPTH on their own. The address only
  // advances when a word is actually enqueued, so a rejected opcode leaves
  // the next word with the address it would have had anyway. An accept and
  // a pop in the same cycle cancel in the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      next_addr <= BASE_ADDR;
      err       <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr    <= wr_ptr + PW'(1);
        next_addr <= next_addr + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      err <= accept && (!enc_supported || enc_trunc);
    end
  end

  // Head presentation. Outputs are forced to zero when the FIFO is empty so
  // stale storage never leaks out after reset or a drain.
  always_comb begin
    out_instr  = out_valid ? instr_mem[rd_ptr] : '0;
    out_addr   = out_valid ? addr_mem[rd_ptr]  : '0;
    fifo_count = count;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Scoreboard bench for instr_encoder. The driver issues requests and, on the
// cycles the reference model says a request is taken, pushes the expected
// word/address into a queue and records whether an err pulse is due. A
// separate monitor samples the DUT every cycle away from the clock edge and
// compares occupancy, handshakes, the err pulse and the head entry against
// the model. The reference encoder builds words from the RV32I field layout
// with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic        req_funct7;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [$clog2(DEPTH):0] fifo_count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

  entry_t      exp_q[$];
  logic [31:0] exp_addr;
  bit          push_now;
  bit          err_nxt;
  bit          err_cur;
  int          ready_mode;
  int          checks;
  int          errors;

  instr_encoder #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_funct3 (req_funct3),
    .req_funct7 (req_funct7),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .err        (err),
    .fifo_count (fifo_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and reports actual against required on a miss.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint bits(input longint x, input int hi, input int lo);
    return (x >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
  endfunction

  // Reference encoder: places each field at its bit offset by arithmetic and
  // judges immediate range with signed integer comparisons.
  function automatic logic [31:0] model_encode(
    input logic [6:0] op, input logic [2:0] f3, input logic f7,
    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [31:0] imm, output bit sup, output bit bad);
    longint u, s, w, o, d, f, a, b, h;
    u = longint'(imm);
    s = longint'($signed(imm));
    o = longint'(op);
    d = longint'(rd)  << 7;
    f = longint'(f3)  << 12;
    a = longint'(rs1) << 15;
    b = longint'(rs2) << 20;
    h = longint'(f7)  << 30;
    sup = 1'b1;
    bad = 1'b0;
    w = 0;
    case (op)
      7'b0110011: w = o + d + f + a + b + h;
      7'b0000011, 7'b1100111: begin
        w = o + d + f + a + (bits(u, 11, 0) << 20);
        bad = (s < -2048) || (s > 2047);
      end
      7'b0010011: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          w = o + d + f + a + (bits(u, 4, 0) << 20) + h;
          bad = (s < 0) || (s > 31);
        end else begin
          w = o + d + f + a + (bits(u, 11, 0) << 20);
          bad = (s < -2048) || (s > 2047);
        end
      end
      7'b0100011: begin
        w = o + (bits(u, 4, 0) << 7) + f + a + b + (bits(u, 11, 5) << 25);
        bad = (s < -2048) || (s > 2047);
      end
      7'b1100011: begin
        w = o + (bits(u, 11, 11) << 7) + (bits(u, 4, 1) << 8) + f + a + b
              + (bits(u, 10, 5) << 25) + (bits(u, 12, 12) << 31);
        bad = (s < -4096) || (s > 4095) || ((u % 2) != 0);
      end
      7'b0010111, 7'b0110111: w = o + d + (bits(u, 31, 12) << 12);
      7'b1101111: begin
        w = o + d + (bits(u, 19, 12) << 12) + (bits(u, 11, 11) << 20)
              + (bits(u, 10, 1) << 21) + (bits(u, 20, 20) << 31);
        bad = (s < -(longint'(1) << 20)) || (s >= (longint'(1) << 20))
              || ((u % 2) != 0);
      end
      default: sup = 1'b0;
    endcase
    return 32'(w);
  endfunction

  task automatic driveReady();
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Presents one request and holds it until the model says it is taken.
  // use_want substitutes a literal expected word; release_after >= 0 turns
  // the consumer on after that many refused cycles.
  task automatic applyStimulus(
    input logic [6:0] op, input logic [2:0] f3, input logic f7,
    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [31:0] imm, input bit use_want, input logic [31:0] want,
    input int release_after);
    bit          sup;
    bit          bad;
    bit          acc;
    int          waited;
    logic [31:0] w;
    entry_t      e;
    w = model_encode(op, f3, f7, rd, rs1, rs2, imm, sup, bad);
    if (use_want) w = want;
    acc = 1'b0;
    waited = 0;
    while (!acc) begin
      @(negedge clk);
      if (release_after >= 0 && waited >= release_after) ready_mode = 1;
      driveReady();
      req_valid  = 1'b1;
      req_opcode = op;
      req_funct3 = f3;
      req_funct7 = f7;
      req_rd     = rd;
      req_rs1    = rs1;
      req_rs2    = rs2;
      req_imm    = imm;
      #2;
      if (!rst && exp_q.size() < DEPTH) begin
        acc = 1'b1;
        if (sup) begin
          e.instr = w;
          e.addr  = exp_addr;
          exp_q.push_back(e);
          exp_addr = exp_addr + 32'd4;
          push_now = 1'b1;
        end
        err_nxt = !sup || bad;
      end else begin
        waited++;
        if (waited > 200) begin
          checks++;
          errors++;
          $display("[TB] FAIL accept_timeout: waited %0d cycles, required <= 200", waited);
          return;
        end
      end
    end
  endtask

  task automatic applyIdle(input int n);
    repeat (n) begin
      @(negedge clk);
      driveReady();
      req_valid = 1'b0;
    end
  endtask

  // One-cycle reset with a request presented that must not be taken.
  task automatic applyReset();
    @(negedge clk);
    driveReady();
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_opcode = 7'b0110011;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
  endtask

  // Monitor: samples 4 time units after the falling edge. Entries the driver
  // pushed this cycle are not in the DUT until the next rising edge, so they
  // are excluded from the model occupancy.
  initial begin : monitor
    int pend;
    int mcount;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #4;
      pend = push_now ? 1 : 0;
      push_now = 1'b0;
      mcount = exp_q.size() - pend;
      checkOutput("fifo_count", 64'(fifo_count), 64'(mcount));
      checkOutput("req_ready", 64'(req_ready), 64'(!rst && mcount != DEPTH));
      checkOutput("out_valid", 64'(out_valid), 64'(mcount != 0));
      checkOutput("err", 64'(err), 64'(err_cur));
      err_cur = err_nxt;
      err_nxt = 1'b0;
      if (out_valid && mcount > 0) begin
        checkOutput("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
        checkOutput("out_addr", 64'(out_addr), 64'(exp_q[0].addr));
        if (out_ready && !rst) void'(exp_q.pop_front());
      end else if (!out_valid) begin
        checkOutput("idle_instr", 64'(out_instr), 64'(0));
        checkOutput("idle_addr", 64'(out_addr), 64'(0));
      end
      if (rst) begin
        exp_q.delete();
        exp_addr = BASE;
        err_cur  = 1'b0;
        err_nxt  = 1'b0;
      end
    end
  end

  // Main sequence: directed cases first, then randomized traffic, then drain.
  initial begin : driver
    logic [6:0] ops [9];
    logic [6:0] op;
    logic [31:0] imm;
    int n;
    ops = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011,
            7'b0010111, 7'b0110111, 7'b1100111, 7'b1101111};
    checks = 0;
    errors = 0;
    exp_addr = BASE;
    push_now = 1'b0;
    err_nxt = 1'b0;
    err_cur = 1'b0;
    ready_mode = 1;
    rst = 1'b1;
    req_valid = 1'b0;
    req_opcode = '0;
    req_funct3 = '0;
    req_funct7 = 1'b0;
    req_rd = '0;
    req_rs1 = '0;
    req_rs2 = '0;
    req_imm = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed encodings");
    applyStimulus(7'b0110011, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h002081B3, -1);
    applyStimulus(7'b0110011, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 32'd0, 1, 32'h407302B3, -1);
    applyStimulus(7'b0110111, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h12345000, 1, 32'h12345137, -1);
    applyStimulus(7'b1100011, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1, 32'h00208463, -1);
    applyStimulus(7'b1101111, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1, 32'h001000EF, -1);
    applyStimulus(7'b1100011, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd9, 0, 32'h0, -1);
    applyIdle(3);

    $display("[TB] backpressure with full FIFO");
    ready_mode = 0;
    applyStimulus(7'b0010011, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd5, 0, 32'h0, -1);
    applyStimulus(7'b0010011, 3'd0, 1'b0, 5'd2, 5'd3, 5'd0, -32'sd7, 0, 32'h0, -1);
    applyStimulus(7'b0100011, 3'd2, 1'b0, 5'd0, 5'd4, 5'd5, 32'd100, 0, 32'h0, 3);
    applyIdle(4);

    $display("[TB] unsupported opcode");
    applyStimulus(7'h7F, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 0, 32'h0, -1);
    applyStimulus(7'b0110011, 3'd7, 1'b0, 5'd9, 5'd10, 5'd11, 32'd0, 0, 32'h0, -1);
    applyIdle(3);

    $display("[TB] reset mid-operation");
    ready_mode = 0;
    applyStimulus(7'b0110011, 3'd4, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 0, 32'h0, -1);
    applyStimulus(7'b0010111, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'hABCDE000, 0, 32'h0, -1);
    applyReset();
    ready_mode = 1;
    applyStimulus(7'b0110011, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h002081B3, -1);
    applyIdle(3);

    $display("[TB] randomized traffic");
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        applyIdle(1);
      end else begin
        if ($urandom_range(0, 9) == 0) op = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'h00;
        else op = ops[$urandom_range(0, 8)];
        case ($urandom_range(0, 3))
          0:       imm = 32'($urandom_range(0, 63)) - 32'd32;
          1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
          2:       imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
          default: imm = $urandom();
        endcase
        if ($urandom_range(0, 3) != 0) imm[0] = 1'b0;
        applyStimulus(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), imm, 0, 32'h0, -1);
      end
    end

    ready_mode = 1;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      applyIdle(1);
      n++;
    end
    applyIdle(2);
    checkOutput("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, 32'h0, byte address assigned to the first emitted instruction word.
REQ-002 Parameter DEPTH, 2, output FIFO entries (power of two, >=2).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  request accepted this cycle when req_valid also high.
REQ-007 req_opcode  in  7  instruction class: R 0110011, I-load 0000011, I-ALU 0010011, S 0100011, B 1100011, AUIPC 0010111, LUI 0110111, JALR 1100111, JAL 1101111.
REQ-008 req_funct3  in  3  funct3 field.
REQ-009 req_funct7  in  1  instruction bit 30 (SUB / arithmetic variant).
REQ-010 req_rd, req_rs1, req_rs2  in  5 each  register indices.
REQ-011 req_imm  in  32  signed byte immediate (U-type: upper 20 bits used).
REQ-012 out_valid  out  1  head FIFO entry valid.
REQ-013 out_ready  in  1  consumer (instruction-memory writer) takes head entry.
REQ-014 out_instr  out  32  encoded instruction word of head entry.
REQ-015 out_addr  out  32  byte address of head entry.
REQ-016 err  out  1  one-cycle pulse: request rejected or immediate truncated.
REQ-017 fifo_count  out  $clog2(DEPTH)+1  entries held.

Function
REQ-018 Accept = req_valid && req_ready; req_ready = !rst && fifo_count != DEPTH; no combinational path from out_ready to req_ready.
REQ-019 Pop = out_valid && out_ready; out_valid = fifo_count != 0; head fields stable while out_valid && !out_ready.
REQ-020 Accepted word enters FIFO at the accepting edge; earliest out_valid is the following cycle (latency 1).
REQ-021 Simultaneous accept and pop in one cycle: count unchanged, order preserved.
REQ-022 Fields: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20] where format has them; unused fields zero.
REQ-023 R: [31:25] = {1'b0, funct7, 5'b0}.
REQ-024 I-load, I-ALU, JALR: [31:20] = imm[11:0]; I-ALU funct3 001/101: [31:25] = {1'b0, funct7, 5'b0}, [24:20] = imm[4:0].
REQ-025 S: [31:25] = imm[11:5], [11:7] = imm[4:0].
REQ-026 B: [31] imm[12], [30:25] imm[10:5], [11:8] imm[4:1], [7] imm[11].
REQ-027 AUIPC/LUI: [31:12] = imm[31:12].
REQ-028 JAL: [31] imm[20], [30:21] imm[10:1], [20] imm[11], [19:12] imm[19:12].
REQ-029 Immediate outside the format's signed range, or imm[0]=1 for B/JAL: word still encoded from low bits, err pulses the cycle after accept.
REQ-030 Unsupported opcode: request accepted (consumed), nothing enqueued, address unchanged, err pulses the cycle after accept.
REQ-031 Address counter: entry address = BASE_ADDR + 4 x (words enqueued since reset), assigned at enqueue; wraps modulo 2^32.
REQ-032 FIFO pointers wrap modulo DEPTH; full blocks accept, empty deasserts out_valid, no overflow/underflow under any input.

Reset
REQ-033 During/after rst: fifo_count 0, out_valid 0, err 0, req_ready 0 while rst high, next address BASE_ADDR, out_instr/out_addr 0.
REQ-034 rst mid-operation discards all FIFO entries and any pending err; request presented in the reset cycle is not accepted.

Verification
REQ-035 ADD x3,x1,x2 (opcode 0110011, f3 0, f7 0), out_ready=1 -> next cycle out_instr 32'h002081B3, out_addr BASE_ADDR.
REQ-036 SUB x5,x6,x7 then LUI x2 imm 32'h12345000 -> 32'h407302B3 @BASE, 32'h12345137 @BASE+4.
REQ-037 BEQ x1,x2 imm 8 -> 32'h00208463; JAL x1 imm 2048 -> 32'h001000EF; BEQ imm 9 -> err pulse, word still emitted.
REQ-038 out_ready=0, three back-to-back requests -> req_ready low after two (DEPTH=2), third held; release -> three words at BASE, +4, +8 in order, no loss.
REQ-039 Opcode 7'h7F -> err high one cycle, fifo_count unchanged, next valid word gets the not-yet-used address.
REQ-040 Two words queued, rst for one cycle -> fifo_count 0, out_valid 0, next word at BASE_ADDR.
